fret_table_reader: RTL and testbench
====================================

Name: fret_table_reader

Overview:
- Read-side companion to the dual-port block RAM: owns RAM port B and never writes it.
- On each frame-start pulse it scans the fret table at BASE_ADDR..BASE_ADDR+NUM_ENTRIES-1 and fills a back shadow buffer.
- On completion it swaps the back buffer into a front buffer, so the VGA renderer always sees one consistent frame of fret data while the CPU rewrites the table through port A.

Parameters:
- BASE_ADDR, 16'hF000, first word of the fret table
- NUM_ENTRIES, 20, number of fret words scanned (1..31)
- DATA_W, 16, RAM word width
- ADDR_W, 16, RAM address width

Ports:
- clk  in  1  system clock; same clock as the RAM
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse from VGA timing at vblank start
- mem_addr  out  ADDR_W  drives RAM port B address
- mem_we  out  1  drives RAM port B write enable; constant 0
- mem_wdata  out  DATA_W  drives RAM port B write data; constant 0
- mem_rdata  in  DATA_W  RAM port B registered read data
- entry_sel  in  5  fret index queried by the renderer
- entry_lane  out  4  front-buffer word[15:12] for entry_sel
- entry_pos  out  12  front-buffer word[11:0] for entry_sel
- busy  out  1  scan in progress
- snap_valid  out  1  front buffer holds at least one completed scan
- overrun  out  1  sticky; frame_start arrived while busy
- range_err  out  1  sticky position-range flag (optional feature)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; mem_addr=BASE_ADDR; busy, snap_valid, overrun, range_err = 0
  - both buffers cleared to 0; index counters = 0
- RAM read latency: exactly 1 cycle (address at edge n, data valid after edge n+1).
- FSM IDLE -> ISSUE -> DRAIN -> SWAP -> IDLE.
  - IDLE: frame_start=1 -> ISSUE; rd_idx=0; busy=1 from next cycle.
  - ISSUE: mem_addr=BASE_ADDR+rd_idx; rd_idx increments each cycle; after issuing index NUM_ENTRIES-1 -> DRAIN.
  - Capture path: a one-cycle delayed valid/index pair (cap_vld, cap_idx) writes mem_rdata into back[cap_idx]. It runs during ISSUE cycles 2..N and DRAIN.
  - DRAIN: captures the last word -> SWAP.
  - SWAP: front <= back (all entries, one cycle); snap_valid <= 1; busy <= 0 next cycle -> IDLE.
- Timing with frame_start sampled at cycle 0:
  - addresses on cycles 1..20
  - data captured on cycles 2..21
  - swap at cycle 22
  - front updated and visible from cycle 23
- frame_start while busy: ignored (no restart); overrun <= 1, cleared only by reset.
- frame_start in the SWAP cycle: counts as busy.
- frame_start on the cycle after SWAP (IDLE): accepted.
- mem_addr holds its last value in IDLE. The address sum is ADDR_W wide and wraps modulo 2^ADDR_W.
- Read path (entry_lane, entry_pos): combinational from the front buffer. entry_sel >= NUM_ENTRIES returns 0/0.
- Front buffer is never partially updated; a reset mid-scan discards the back buffer.

Optional Feature:
- Macro: FRET_RANGE_CHECK_EN
- With the macro:
  - Any captured word with pos > 479 is stored with pos clamped to 479 (lane kept).
  - range_err <= 1 (sticky until reset).
- Without the macro:
  - Words are stored verbatim.
  - range_err is tied to 0.

Decomposition:
- Shared package fret_pkg holds:
  - FRET_BASE_ADDR, FRET_NUM_ENTRIES, FRET_POS_MAX=479
  - fret_entry_t {lane[3:0], pos[11:0]}
  - FSM state enum
- One natural sub-module, fret_shadow_buf: back/front register arrays with a write port, swap strobe and combinational read mux.

Test Plan:
- Reset, no frame_start -> snap_valid=0, busy=0, mem_addr=16'hF000, entry_sel=0 returns lane 0 / pos 0.
- RAM F000..F013 preloaded (F001={1,100}, F005={0,500}), frame_start at cycle 0:
  - mem_addr=F000 at cycle 1 through F013 at cycle 20
  - busy deasserts after cycle 22
  - entry_sel=1 -> lane 1, pos 100
- Second frame_start pulse at cycle 10 -> no restart, overrun=1, first scan completes with correct data.
- Port A writes F003={3,200} at cycle 15 of a scan (address already read) -> front shows the old value; the next scan shows {3,200}.
- rst_n asserted at cycle 12 mid-scan -> all outputs are at reset values immediately; the next scan produces correct data.
- With FRET_RANGE_CHECK_EN, F006={2,600} -> entry_pos=479, entry_lane=2, range_err=1. Without the macro -> pos=600, range_err=0.

Source files
------------

// File: rtl/fret_pkg.sv
// Shared types and constants for the fret table reader slice.
package fret_pkg;

  localparam logic [15:0] FRET_BASE_ADDR   = 16'hF000;
  localparam int unsigned FRET_NUM_ENTRIES = 20;
  localparam logic [11:0] FRET_POS_MAX     = 12'd479;

  typedef struct packed {
    logic [3:0]  lane;
    logic [11:0] pos;
  } fret_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_SWAP
  } fret_state_t;

endpackage

// File: rtl/fret_table_reader_if.sv
// RAM port B bus between the fret table reader (master) and the block RAM (slave).
interface fret_table_reader_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/fret_shadow_buf.sv
// Back/front fret register arrays: back filled word by word, front replaced whole on swap.
module fret_shadow_buf
  import fret_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = FRET_NUM_ENTRIES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [4:0]  wr_idx,
  input  fret_entry_t wr_data,
  input  logic        swap,
  input  logic [4:0]  rd_sel,
  output fret_entry_t rd_data
);

  fret_entry_t back_q  [NUM_ENTRIES];
  fret_entry_t back_d  [NUM_ENTRIES];
  fret_entry_t front_q [NUM_ENTRIES];
  fret_entry_t front_d [NUM_ENTRIES];

  always_comb begin
    back_d  = back_q;
    front_d = front_q;
    if (wr_en && (wr_idx < 5'(NUM_ENTRIES))) back_d[wr_idx] = wr_data;
    if (swap) front_d = back_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      back_q  <= '{default: '0};
      front_q <= '{default: '0};
    end else begin
      back_q  <= back_d;
      front_q <= front_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_sel < 5'(NUM_ENTRIES)) rd_data = front_q[rd_sel];
  end

endmodule

// File: rtl/fret_table_reader.sv
// Scans the fret table through RAM port B each frame and double-buffers it for the renderer.
// Optional position clamping and range_err flag enabled by FRET_RANGE_CHECK_EN.
module fret_table_reader
  import fret_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       NUM_ENTRIES = FRET_NUM_ENTRIES,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = FRET_BASE_ADDR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  fret_table_reader_if.master mem,
  input  logic [4:0]          entry_sel,
  output logic [3:0]          entry_lane,
  output logic [11:0]         entry_pos,
  output logic                busy,
  output logic                snap_valid,
  output logic                overrun,
  output logic                range_err
);

  fret_state_t       state_q, state_d;
  logic [4:0]        rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_vld_q, addr_vld_d;
  logic [4:0]        addr_idx_q, addr_idx_d;
  logic              cap_vld_q, cap_vld_d;
  logic [4:0]        cap_idx_q, cap_idx_d;
  logic              busy_q, busy_d;
  logic              snap_valid_q, snap_valid_d;
  logic              overrun_q, overrun_d;
  logic              swap;
  logic [DATA_W-1:0] rdata;
  fret_entry_t       cap_word;
  fret_entry_t       wr_word;
  fret_entry_t       rd_word;

  assign rdata    = mem.mem_rdata;
  assign cap_word = rdata;

  // Address is registered, RAM output is registered: capture lags issue by two edges.
  always_comb begin
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    addr_d       = addr_q;
    addr_vld_d   = 1'b0;
    addr_idx_d   = addr_idx_q;
    cap_vld_d    = addr_vld_q;
    cap_idx_d    = addr_idx_q;
    busy_d       = busy_q;
    snap_valid_d = snap_valid_q;
    overrun_d    = overrun_q;
    swap         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d  = ST_ISSUE;
          rd_idx_d = '0;
          busy_d   = 1'b1;
        end
      end
      ST_ISSUE: begin
        addr_d     = BASE_ADDR + ADDR_W'(rd_idx_q);
        addr_vld_d = 1'b1;
        addr_idx_d = rd_idx_q;
        rd_idx_d   = rd_idx_q + 5'd1;
        if (rd_idx_q == 5'(NUM_ENTRIES - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cap_vld_q && (cap_idx_q == 5'(NUM_ENTRIES - 1))) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        swap         = 1'b1;
        snap_valid_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_start && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_idx_q     <= '0;
      addr_q       <= BASE_ADDR;
      addr_vld_q   <= 1'b0;
      addr_idx_q   <= '0;
      cap_vld_q    <= 1'b0;
      cap_idx_q    <= '0;
      busy_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      addr_q       <= addr_d;
      addr_vld_q   <= addr_vld_d;
      addr_idx_q   <= addr_idx_d;
      cap_vld_q    <= cap_vld_d;
      cap_idx_q    <= cap_idx_d;
      busy_q       <= busy_d;
      snap_valid_q <= snap_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef FRET_RANGE_CHECK_EN
  logic range_err_q, range_err_d;
  logic pos_high;

  assign pos_high = cap_word.pos > FRET_POS_MAX;

  always_comb begin
    wr_word     = cap_word;
    range_err_d = range_err_q;
    if (cap_vld_q && pos_high) begin
      wr_word.pos = FRET_POS_MAX;
      range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) range_err_q <= 1'b0;
    else        range_err_q <= range_err_d;
  end

  assign range_err = range_err_q;
`else
  assign wr_word   = cap_word;
  assign range_err = 1'b0;
`endif

  fret_shadow_buf #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (cap_vld_q),
    .wr_idx (cap_idx_q),
    .wr_data(wr_word),
    .swap   (swap),
    .rd_sel (entry_sel),
    .rd_data(rd_word)
  );

  assign mem.mem_addr  = addr_q;
  assign mem.mem_we    = 1'b0;
  assign mem.mem_wdata = '0;
  assign entry_lane    = rd_word.lane;
  assign entry_pos     = rd_word.pos;
  assign busy          = busy_q;
  assign snap_valid    = snap_valid_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_fret_table_reader.sv
// Scoreboard bench for fret_table_reader: stimulus pushes expected snapshots, monitor checks on scan completion.
module tb_fret_table_reader;
  localparam int NUM = 20;
  typedef logic [NUM*16-1:0] snap_t;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [4:0]  entry_sel;
  logic [3:0]  entry_lane;
  logic [11:0] entry_pos;
  logic        busy, snap_valid, overrun, range_err;

  logic [15:0] ram [32];
  snap_t       sb_q [$];
  int          vecs  = 0;
  int          fails = 0;

`ifdef FRET_RANGE_CHECK_EN
  localparam logic RERR_EXP = 1'b1;
`else
  localparam logic RERR_EXP = 1'b0;
`endif

  fret_table_reader_if bus ();

  fret_table_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .mem        (bus),
    .entry_sel  (entry_sel),
    .entry_lane (entry_lane),
    .entry_pos  (entry_pos),
    .busy       (busy),
    .snap_valid (snap_valid),
    .overrun    (overrun),
    .range_err  (range_err)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Port B of the block RAM: one-cycle registered read over F000..F01F.
  always @(posedge clk)
    bus.mem_rdata <= (bus.mem_addr[15:5] == 11'h780) ? ram[bus.mem_addr[4:0]] : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic snap_t build_snap();
    snap_t s;
    logic [15:0] w;
    s = '0;
    for (int i = 0; i < NUM; i++) begin
      w = ram[i];
`ifdef FRET_RANGE_CHECK_EN
      if (w[11:0] > 12'd479) w[11:0] = 12'd479;
`endif
      s[i*16 +: 16] = w;
    end
    return s;
  endfunction

  // Monitor: on each busy fall the front buffer holds a finished scan.
  initial begin
    snap_t       exp_s;
    logic [15:0] exp_w;
    logic        prev_busy;
    entry_sel = 5'd0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_busy = 1'b0;
      else begin
        if (prev_busy && !busy) begin
          if (sb_q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
          else begin
            exp_s = sb_q.pop_front();
            for (int i = 0; i < NUM + 2; i++) begin
              entry_sel = (i < NUM) ? 5'(i) : ((i == NUM) ? 5'd20 : 5'd31);
              exp_w = (i < NUM) ? exp_s[i*16 +: 16] : 16'h0000;
              #1;
              chk($sformatf("entry[%0d]", entry_sel), {16'h0, entry_lane, entry_pos}, {16'h0, exp_w});
            end
            chk("snap_valid", {31'h0, snap_valid}, 32'd1);
            entry_sel = 5'd0;
          end
        end
        prev_busy = busy;
      end
    end
  end

  // extra_k: cycle of an extra frame_start pulse; wr_k: cycle of a port A write; rst_k: cycle of reset.
  task automatic run_scan(input int extra_k, input int wr_k, input int rst_k);
    @(posedge clk);
    #1 frame_start = 1'b1;
    sb_q.push_back(build_snap());
    @(posedge clk);
    #1 frame_start = 1'b0;
    for (int k = 0; k <= 23; k++) begin
      @(negedge clk);
      if (k == rst_k) begin
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_snap_valid", {31'h0, snap_valid}, 32'd0);
        chk("rst_overrun", {31'h0, overrun}, 32'd0);
        chk("rst_range_err", {31'h0, range_err}, 32'd0);
        chk("rst_mem_addr", {16'h0, bus.mem_addr}, 32'h0000F000);
        chk("rst_entry0", {16'h0, entry_lane, entry_pos}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k >= 1 && k <= 20) chk($sformatf("mem_addr@%0d", k), {16'h0, bus.mem_addr}, 32'h0000F000 + 32'(k - 1));
      if (k == 22) chk("busy@22", {31'h0, busy}, 32'd1);
      if (k == 23) chk("busy@23", {31'h0, busy}, 32'd0);
      if (k == extra_k - 1) frame_start = 1'b1;
      if (k == extra_k) frame_start = 1'b0;
      if (k == wr_k) ram[3] = {4'd3, 12'd200};
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < 32; i++) ram[i] = {4'(i % 4), 12'(20 * i + 3)};
    ram[1] = {4'd1, 12'd100};
    ram[5] = {4'd0, 12'd500};
    repeat (3) @(negedge clk);
    chk("reset_snap_valid", {31'h0, snap_valid}, 32'd0);
    chk("reset_busy", {31'h0, busy}, 32'd0);
    chk("reset_mem_addr", {16'h0, bus.mem_addr}, 32'h0000F000);
    chk("reset_entry0", {16'h0, entry_lane, entry_pos}, 32'd0);
    chk("reset_mem_we", {31'h0, bus.mem_we}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_scan(-5, -5, -5);
    chk("overrun_scan1", {31'h0, overrun}, 32'd0);
    chk("range_err_scan1", {31'h0, range_err}, {31'h0, RERR_EXP});

    run_scan(10, -5, -5);
    chk("overrun_scan2", {31'h0, overrun}, 32'd1);

    run_scan(-5, 15, -5);
    run_scan(-5, -5, -5);

    run_scan(-5, -5, 12);
    repeat (2) @(negedge clk);
    chk("post_rst_overrun", {31'h0, overrun}, 32'd0);

    ram[5] = {4'd0, 12'd400};
    ram[6] = {4'd2, 12'd600};
    run_scan(23, -5, -5);
    chk("overrun_swap_pulse", {31'h0, overrun}, 32'd1);
    chk("range_err_f006", {31'h0, range_err}, {31'h0, RERR_EXP});

    run_scan(-5, -5, -5);
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("mem_wdata", {16'h0, bus.mem_wdata}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
